priv_hpm_event_unit: RTL and testbench

Parametrised hardware performance monitor engine for the privileged unit. It replaces the fixed hpm_inc wiring with NUM_COUNTERS programmable counters. Each counter selects any of NUM_EVENTS raw pipeline/cache event lines and counts in level, rising-edge or falling-edge mode, with per-counter inhibit and overflow interrupt. It sits between the pipeline event signals and priv_csr: CSR accesses drive its write/read ports, and its overflow interrupt feeds the interrupt/exception handler.

---
 rtl/priv_hpm_event_unit_if.sv | 30 +++
 rtl/priv_hpm_event_unit.sv | 101 ++++++++++
 tb/tb_priv_hpm_event_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/priv_hpm_event_unit_if.sv
// rtl/priv_hpm_event_unit_if.sv - CSR-side config/counter/read bus of the HPM event unit
interface priv_hpm_event_unit_if #(
  parameter int NUM_EVENTS   = 32,
  parameter int NUM_COUNTERS = 29,
  parameter int CNT_WIDTH    = 64,
  parameter int IDX_W        = $clog2(NUM_COUNTERS)
);
  localparam int CFG_W = $clog2(NUM_EVENTS) + 4;

  logic                    cfg_we;
  logic [IDX_W-1:0]        cfg_idx;
  logic [CFG_W-1:0]        cfg_wdata;
  logic                    cnt_we;
  logic [IDX_W-1:0]        cnt_idx;
  logic [CNT_WIDTH-1:0]    cnt_wdata;
  logic [NUM_COUNTERS-1:0] ovf_clr;
  logic [IDX_W-1:0]        rd_idx;
  logic [CNT_WIDTH-1:0]    rd_cnt;
  logic [CFG_W-1:0]        rd_cfg;

  modport master (
    output cfg_we, cfg_idx, cfg_wdata, cnt_we, cnt_idx, cnt_wdata, ovf_clr, rd_idx,
    input  rd_cnt, rd_cfg
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_wdata, cnt_we, cnt_idx, cnt_wdata, ovf_clr, rd_idx,
    output rd_cnt, rd_cfg
  );
endinterface

// File: rtl/priv_hpm_event_unit.sv
// rtl/priv_hpm_event_unit.sv - programmable HPM counters with event select, edge modes and overflow irq
module priv_hpm_event_unit #(
  parameter int NUM_EVENTS   = 32,
  parameter int NUM_COUNTERS = 29,
  parameter int CNT_WIDTH    = 64,
  parameter int IDX_W        = $clog2(NUM_COUNTERS)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NUM_EVENTS-1:0]   events,
  input  logic                    freeze,
  priv_hpm_event_unit_if.slave    csr,
  output logic [NUM_COUNTERS-1:0] ovf_flags,
  output logic                    ovf_irq
);
  localparam int SEL_W = $clog2(NUM_EVENTS);
  localparam int CFG_W = SEL_W + 4;
  localparam int PAD_W = 1 << SEL_W;

  logic [CNT_WIDTH-1:0]    cnt_q [NUM_COUNTERS];
  logic [CFG_W-1:0]        cfg_q [NUM_COUNTERS];
  logic [NUM_EVENTS-1:0]   ev_q;
  logic [PAD_W-1:0]        ev_now_pad;
  logic [PAD_W-1:0]        ev_old_pad;
  logic [NUM_COUNTERS-1:0] inc;
  logic [NUM_COUNTERS-1:0] ovf_ie;

  // Zero-pad event lines so select codes past NUM_EVENTS read as a permanently quiet line
  always_comb begin
    ev_now_pad = '0;
    ev_old_pad = '0;
    ev_now_pad[NUM_EVENTS-1:0] = events;
    ev_old_pad[NUM_EVENTS-1:0] = ev_q;
  end

  // Decode each counter's hit from its selected line, mode, inhibit and the global freeze
  always_comb begin
    inc    = '0;
    ovf_ie = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      logic [SEL_W-1:0] sel;
      logic             cur;
      logic             old;
      logic             hit;
      sel = cfg_q[i][SEL_W-1:0];
      cur = ev_now_pad[sel];
      old = ev_old_pad[sel];
      case (cfg_q[i][SEL_W+1:SEL_W])
        2'b01:   hit = cur;
        2'b10:   hit = cur & ~old;
        2'b11:   hit = old & ~cur;
        default: hit = 1'b0;
      endcase
      inc[i]    = hit & ~cfg_q[i][SEL_W+2] & ~freeze;
      ovf_ie[i] = cfg_q[i][SEL_W+3];
    end
  end

  // Read mux; indices with no counter behind them return zero
  always_comb begin
    csr.rd_cnt = '0;
    csr.rd_cfg = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (csr.rd_idx == IDX_W'(i)) begin
        csr.rd_cnt = cnt_q[i];
        csr.rd_cfg = cfg_q[i];
      end
    end
  end

  // Counter, config, overflow and event-history state; a CSR write beats a same-cycle increment
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ev_q      <= '0;
      ovf_flags <= '0;
      ovf_irq   <= 1'b0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt_q[i] <= '0;
        cfg_q[i] <= '0;
      end
    end else begin
      ev_q    <= events;
      ovf_irq <= |(ovf_flags & ovf_ie);
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (csr.cnt_we && csr.cnt_idx == IDX_W'(i)) begin
          cnt_q[i] <= csr.cnt_wdata;
        end else if (inc[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
        if (csr.cfg_we && csr.cfg_idx == IDX_W'(i)) begin
          cfg_q[i] <= csr.cfg_wdata;
        end
        if (inc[i] && !(csr.cnt_we && csr.cnt_idx == IDX_W'(i)) && (&cnt_q[i])) begin
          ovf_flags[i] <= 1'b1;
        end else if (csr.ovf_clr[i]) begin
          ovf_flags[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_priv_hpm_event_unit.sv
// tb/tb_priv_hpm_event_unit.sv - randomized check of priv_hpm_event_unit against a behavioural model
module tb_priv_hpm_event_unit;
  localparam int NE = 32;
  localparam int NC = 29;
  localparam int CW = 64;
  localparam int IW = 5;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic [NE-1:0] events = '0;
  logic          freeze = 1'b0;
  logic [NC-1:0] ovf_flags;
  logic          ovf_irq;

  priv_hpm_event_unit_if bus ();

  priv_hpm_event_unit dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .events    (events),
    .freeze    (freeze),
    .csr       (bus),
    .ovf_flags (ovf_flags),
    .ovf_irq   (ovf_irq)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // reference model state, one field per architectural item
  logic [CW-1:0] m_cnt [NC];
  logic [4:0]    m_sel [NC];
  logic [1:0]    m_mode[NC];
  bit            m_inh [NC];
  bit            m_ie  [NC];
  bit [NC-1:0]   m_flag;
  bit            m_irq;
  bit [NE-1:0]   m_prev;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = '0; m_sel[i] = '0; m_mode[i] = '0; m_inh[i] = 0; m_ie[i] = 0;
    end
    m_flag = '0; m_irq = 0; m_prev = '0;
  endtask

  task automatic model_step();
    bit irq_n;
    irq_n = 0;
    for (int i = 0; i < NC; i++) if (m_flag[i] && m_ie[i]) irq_n = 1;
    for (int i = 0; i < NC; i++) begin
      bit cur, prv, hit, inc, wrap, wr;
      cur = (int'(m_sel[i]) < NE) ? events[m_sel[i]] : 1'b0;
      prv = (int'(m_sel[i]) < NE) ? m_prev[m_sel[i]] : 1'b0;
      case (m_mode[i])
        2'd1:    hit = cur;
        2'd2:    hit = cur && !prv;
        2'd3:    hit = prv && !cur;
        default: hit = 0;
      endcase
      inc  = hit && !m_inh[i] && !freeze;
      wr   = bus.cnt_we && (int'(bus.cnt_idx) == i);
      wrap = 0;
      if (wr) m_cnt[i] = bus.cnt_wdata;
      else if (inc) begin
        if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) begin
          m_cnt[i] = '0;
          wrap = 1;
        end else begin
          m_cnt[i] = m_cnt[i] + 64'd1;
        end
      end
      if (wrap) m_flag[i] = 1;
      else if (bus.ovf_clr[i]) m_flag[i] = 0;
    end
    if (bus.cfg_we && int'(bus.cfg_idx) < NC) begin
      m_sel[bus.cfg_idx]  = bus.cfg_wdata[4:0];
      m_mode[bus.cfg_idx] = bus.cfg_wdata[6:5];
      m_inh[bus.cfg_idx]  = bus.cfg_wdata[7];
      m_ie[bus.cfg_idx]   = bus.cfg_wdata[8];
    end
    m_prev = events;
    m_irq  = irq_n;
  endtask

  task automatic check_all(input string tag);
    logic [63:0] ec;
    logic [8:0]  ecf;
    int r;
    r = int'(bus.rd_idx);
    ec = '0; ecf = '0;
    if (r < NC) begin
      ec  = m_cnt[r];
      ecf = {m_ie[r], m_inh[r], m_mode[r], m_sel[r]};
    end
    check_eq({tag, "_cnt"}, bus.rd_cnt, ec);
    check_eq({tag, "_cfg"}, 64'(bus.rd_cfg), 64'(ecf));
    check_eq({tag, "_flags"}, 64'(ovf_flags), 64'(m_flag));
    check_eq({tag, "_irq"}, 64'(ovf_irq), 64'(m_irq));
  endtask

  task automatic idle();
    bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_wdata = '0;
    bus.cnt_we = 0; bus.cnt_idx = '0; bus.cnt_wdata = '0;
    bus.ovf_clr = '0; events = '0; freeze = 0;
  endtask

  task automatic cycle(input string tag);
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_all(tag);
  endtask

  initial begin
    logic [3:0] pat;
    idle();
    bus.rd_idx = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    events = '1;
    for (int k = 0; k < 4; k++) begin
      bus.rd_idx = IW'(k * 7);
      @(negedge CLK);
      check_all("reset");
    end
    nRST = 1'b1;
    idle();

    // LEVEL on counter 0, line 5, ten cycles
    bus.cfg_we = 1; bus.cfg_idx = 5'd0; bus.cfg_wdata = {1'b0, 1'b0, 2'b01, 5'd5};
    cycle("cfg0");
    idle(); bus.rd_idx = 5'd0; events[5] = 1;
    repeat (10) cycle("lvl");
    check_eq("lvl10", bus.rd_cnt, 64'd10);

    // write collides with increment: write wins
    bus.cnt_we = 1; bus.cnt_idx = 5'd0; bus.cnt_wdata = 64'd100;
    cycle("coll");
    check_eq("coll100", bus.rd_cnt, 64'd100);

    // RISE on counter 1, line 3, pattern 1-1-0-1-0-1
    idle(); bus.cfg_we = 1; bus.cfg_idx = 5'd1; bus.cfg_wdata = {1'b0, 1'b0, 2'b10, 5'd3};
    cycle("cfg1");
    idle(); bus.rd_idx = 5'd1;
    for (int k = 0; k < 6; k++) begin
      pat = 4'b0; events[3] = (k == 2 || k == 4) ? 1'b0 : 1'b1;
      cycle("rise");
    end
    events[3] = 0;
    cycle("rise_end");
    check_eq("rise3", bus.rd_cnt, 64'd3);

    // counter 2 wraps with ovf_ie, then clear
    idle(); bus.rd_idx = 5'd2;
    bus.cnt_we = 1; bus.cnt_idx = 5'd2; bus.cnt_wdata = 64'hFFFF_FFFF_FFFF_FFFE;
    bus.cfg_we = 1; bus.cfg_idx = 5'd2; bus.cfg_wdata = {1'b1, 1'b0, 2'b01, 5'd7};
    cycle("cfg2");
    idle(); events[7] = 1;
    repeat (3) cycle("wrap");
    check_eq("wrap_cnt", bus.rd_cnt, 64'd1);
    check_eq("wrap_flag", 64'(ovf_flags[2]), 64'd1);
    check_eq("wrap_irq", 64'(ovf_irq), 64'd1);
    idle(); bus.ovf_clr[2] = 1;
    cycle("clr");
    check_eq("clr_flag", 64'(ovf_flags[2]), 64'd0);
    idle();
    cycle("clr2");
    check_eq("clr_irq", 64'(ovf_irq), 64'd0);

    // wrap and clear in the same cycle: set wins
    bus.cnt_we = 1; bus.cnt_idx = 5'd2; bus.cnt_wdata = '1;
    cycle("prewrap");
    idle(); events[7] = 1; bus.ovf_clr[2] = 1;
    cycle("setwins");
    check_eq("setwins_flag", 64'(ovf_flags[2]), 64'd1);

    // out-of-range config index leaves state untouched
    idle(); bus.cfg_we = 1; bus.cfg_idx = 5'd29; bus.cfg_wdata = 9'h1FF;
    bus.rd_idx = 5'd29;
    cycle("oor");
    check_eq("oor_cfg", 64'(bus.rd_cfg), 64'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      events        = $urandom();
      freeze        = ($urandom_range(0, 7) == 0);
      bus.cfg_we    = ($urandom_range(0, 3) == 0);
      bus.cfg_idx   = IW'($urandom_range(0, 31));
      bus.cfg_wdata = 9'($urandom_range(0, 511));
      bus.cnt_we    = ($urandom_range(0, 7) == 0);
      bus.cnt_idx   = IW'($urandom_range(0, 31));
      bus.cnt_wdata = ($urandom_range(0, 1) == 0) ? {$urandom(), $urandom()}
                                                  : (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)));
      bus.ovf_clr   = ($urandom_range(0, 7) == 0) ? NC'($urandom()) : '0;
      bus.rd_idx    = IW'($urandom_range(0, 31));
      cycle("rnd");
      if (n == 1500) begin
        nRST = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        @(negedge CLK);
        check_all("midrst2");
        nRST = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
